vga_fb_scan_arbiter: RTL

Shares the single-port NES framebuffer RAM between the PPU pixel writer and VGA scanout line prefetch. On each qualifying VGA line start, it bursts one 256-pixel NES row out of the framebuffer into a double-banked line buffer. The writer is guaranteed a periodic slot during the burst and has the port freely otherwise. It sits between the 640x480 VGA timing generator, the framebuffer RAM and the scanline buffer; each NES row is shown twice (2x vertical scaling).

---
 rtl/vga_fb_scan_arbiter_pkg.sv | 16 +
 rtl/vga_fb_rd_pipe.sv | 41 ++++
 rtl/vga_fb_scan_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vga_fb_scan_arbiter_pkg.sv
// Shared constants and FSM state type for the framebuffer scan arbiter.
// Geometry is the NES picture; addresses are {row, col} and {bank, col}.
package vga_fb_scan_arbiter_pkg;

  localparam int unsigned NES_W = 256;
  localparam int unsigned NES_H = 240;
  localparam int unsigned PIX_W = 6;
  localparam int unsigned FB_AW = 16;
  localparam int unsigned LB_AW = 9;

  typedef enum logic {
    StIdle,
    StFetch
  } state_e;

endpackage

// File: rtl/vga_fb_rd_pipe.sv
// Read-return stage: remembers where each framebuffer read belongs and
// turns the RAM data into a line-buffer write one cycle after issue.
module vga_fb_rd_pipe
  import vga_fb_scan_arbiter_pkg::*;
(
  input  logic             i_dclk,
  input  logic             i_clr_n,
  input  logic             i_issue,
  input  logic             i_bank,
  input  logic [7:0]       i_col,
  input  logic [PIX_W-1:0] i_rdata,
  output logic             o_lb_we,
  output logic [LB_AW-1:0] o_lb_addr,
  output logic [PIX_W-1:0] o_lb_data,
  output logic             o_pending
);

  logic       r_valid;
  logic       r_bank;
  logic [7:0] r_col;

  always_ff @(posedge i_dclk) begin
    if (!i_clr_n) begin
      r_valid <= 1'b0;
      r_bank  <= 1'b0;
      r_col   <= '0;
    end else begin
      r_valid <= i_issue;
      if (i_issue) begin
        r_bank <= i_bank;
        r_col  <= i_col;
      end
    end
  end

  assign o_lb_we   = r_valid;
  assign o_lb_addr = {r_bank, r_col};
  assign o_lb_data = i_rdata;
  assign o_pending = r_valid;

endmodule

// File: rtl/vga_fb_scan_arbiter.sv
// Shares the single-port NES framebuffer between the PPU writer and a
// per-line 256-pixel prefetch into a double-banked VGA line buffer.
module vga_fb_scan_arbiter
  import vga_fb_scan_arbiter_pkg::*;
#(
  parameter int unsigned WR_SLOT_PERIOD = 4,
  parameter int unsigned ACTIVE_LINES   = 480
) (
  input  logic             i_dclk,
  input  logic             i_clr_n,
  input  logic             i_line_start,
  input  logic [9:0]       i_y,
  input  logic             i_wr_req,
  input  logic [FB_AW-1:0] i_wr_addr,
  input  logic [PIX_W-1:0] i_wr_data,
  output logic             o_wr_gnt,
  output logic             o_fb_en,
  output logic             o_fb_we,
  output logic [FB_AW-1:0] o_fb_addr,
  output logic [PIX_W-1:0] o_fb_wdata,
  input  logic [PIX_W-1:0] i_fb_rdata,
  output logic             o_lb_we,
  output logic [LB_AW-1:0] o_lb_addr,
  output logic [PIX_W-1:0] o_lb_data,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int unsigned SlotW = $clog2(WR_SLOT_PERIOD);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(WR_SLOT_PERIOD - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [7:0]       r_row;
  logic [7:0]       r_col;
  logic             r_bank;
  logic [SlotW-1:0] r_slot_cnt;
  logic             r_overrun;

  logic w_qual;
  logic w_steal;
  logic w_rd;
  logic w_last_rd;
  logic w_pending;
  logic w_busy;
  logic w_start;

  // Odd VGA rows repeat the previous NES row, so only even rows fetch.
  assign w_qual    = i_line_start && (i_y < 10'(ACTIVE_LINES)) && !i_y[0];
  assign w_steal   = (r_state == StFetch) && (r_slot_cnt == SlotLast) && i_wr_req;
  assign w_rd      = (r_state == StFetch) && !w_steal;
  assign w_last_rd = w_rd && (r_col == 8'(NES_W - 1));
  assign w_busy    = (r_state == StFetch) || w_pending;
  assign w_start   = (r_state == StIdle) && (w_state_nxt == StFetch);

  always_ff @(posedge i_dclk) begin
    if (!i_clr_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_qual && !w_busy) w_state_nxt = StFetch;
      StFetch: if (w_last_rd) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_wr_gnt   = 1'b0;
    o_fb_en    = 1'b0;
    o_fb_we    = 1'b0;
    o_fb_addr  = i_wr_addr;
    o_fb_wdata = i_wr_data;
    unique case (r_state)
      StIdle: begin
        if (i_wr_req) begin
          o_wr_gnt = 1'b1;
          o_fb_en  = 1'b1;
          o_fb_we  = 1'b1;
        end
      end
      StFetch: begin
        o_fb_en = 1'b1;
        if (w_steal) begin
          o_wr_gnt = 1'b1;
          o_fb_we  = 1'b1;
        end else begin
          o_fb_addr = {r_row, r_col};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_dclk) begin
    if (!i_clr_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_bank     <= 1'b0;
      r_slot_cnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_start) begin
        r_row      <= i_y[8:1];
        r_bank     <= i_y[1];
        r_col      <= '0;
        r_slot_cnt <= '0;
      end else if (r_state == StFetch) begin
        r_slot_cnt <= (r_slot_cnt == SlotLast) ? '0 : r_slot_cnt + SlotW'(1);
        if (w_rd) r_col <= r_col + 8'd1;
      end
      // A request that cannot be served is dropped; the flag records it.
      if (w_qual && w_busy) r_overrun <= 1'b1;
    end
  end

  vga_fb_rd_pipe u_rd_pipe (
    .i_dclk    (i_dclk),
    .i_clr_n   (i_clr_n),
    .i_issue   (w_rd),
    .i_bank    (r_bank),
    .i_col     (r_col),
    .i_rdata   (i_fb_rdata),
    .o_lb_we   (o_lb_we),
    .o_lb_addr (o_lb_addr),
    .o_lb_data (o_lb_data),
    .o_pending (w_pending)
  );

  assign o_busy    = w_busy;
  assign o_overrun = r_overrun;

endmodule
